// File: rtl/params_noc.sv
// Router-wide constants and the output-port encoding shared by the NoC blocks.
package params_noc;

  localparam int in_Port_Cnt = 5;
  localparam int VC_NUM      = 4;
  localparam int REQ_CNT     = in_Port_Cnt * VC_NUM;

  // Output-port encoding produced by route computation.
  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } inout_Port;

  typedef inout_Port port_t;

  localparam int PORT_W = $bits(port_t);

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: grants the first request at or after its pointer,
// wrapping at N-1 -> 0, and moves the pointer past the winner when enabled.
module round_robin_arbiter #(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  input  logic         update_en
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [N-1:0]     w_hi;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Requests at or above the pointer take priority over the wrapped ones.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_hi[j] = req[j] && (PTR_W'(j) >= r_ptr);
    end
  end

  // Pick the lowest upper-half request, else the lowest wrapped request.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    grant   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && w_hi[j]) begin
        w_found  = 1'b1;
        w_idx    = PTR_W'(j);
        grant[j] = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && req[j]) begin
        w_found  = 1'b1;
        w_idx    = PTR_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

  // Advance the pointer to one past the winner only when the grant is used.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (update_en && w_found) begin
      r_ptr <= (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vc_allocator.sv
// Virtual-channel allocator: per output port, picks one requesting input VC
// round-robin and hands it the lowest free downstream VC of that port.
module vc_allocator
  import params_noc::*;
#(
  parameter int vc_Num = VC_NUM
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0]                   vc_req_i,
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0][PORT_W-1:0]       out_port_i,
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0]                   release_i,
  output logic [in_Port_Cnt-1:0][vc_Num-1:0]                   vc_grant_o,
  output logic [in_Port_Cnt-1:0][vc_Num-1:0][$clog2(vc_Num)-1:0] vc_assigned_o,
  output logic [in_Port_Cnt-1:0][vc_Num-1:0]                   vc_busy_o
);

  localparam int VC_W  = $clog2(vc_Num);
  localparam int REQ_N = in_Port_Cnt * vc_Num;

  // Requester k = ip*vc_Num + vc falls out of the packed layout directly.
  logic [REQ_N-1:0]                   w_req_flat;
  logic [REQ_N-1:0][PORT_W-1:0]       w_port_flat;
  logic [in_Port_Cnt-1:0][REQ_N-1:0]  w_cand;
  logic [in_Port_Cnt-1:0][REQ_N-1:0]  w_arb_gnt;
  logic [in_Port_Cnt-1:0]             w_free_any;
  logic [in_Port_Cnt-1:0][VC_W-1:0]   w_free_vc;
  logic [in_Port_Cnt-1:0][vc_Num-1:0] w_set;
  logic [REQ_N-1:0]                   w_gnt_flat;
  logic [REQ_N-1:0][VC_W-1:0]         w_asg_flat;
  logic [in_Port_Cnt-1:0][vc_Num-1:0] r_busy;

  assign w_req_flat  = vc_req_i;
  assign w_port_flat = out_port_i;

  // Candidate decode: requester k competes for output o when it targets o.
  // Port codes outside the encoding match no output and are never granted.
  always_comb begin
    for (int o = 0; o < in_Port_Cnt; o++) begin
      for (int k = 0; k < REQ_N; k++) begin
        w_cand[o][k] = w_req_flat[k] && (w_port_flat[k] == PORT_W'(o));
      end
    end
  end

  // Lowest-index free downstream VC per output (scan downward, last hit wins).
  always_comb begin
    for (int o = 0; o < in_Port_Cnt; o++) begin
      w_free_any[o] = 1'b0;
      w_free_vc[o]  = '0;
      for (int v = vc_Num - 1; v >= 0; v--) begin
        if (!r_busy[o][v]) begin
          w_free_any[o] = 1'b1;
          w_free_vc[o]  = VC_W'(v);
        end
      end
    end
  end

  // One arbiter per output; its pointer only moves when a VC was handed out.
  for (genvar o = 0; o < in_Port_Cnt; o++) begin : g_arb
    round_robin_arbiter #(
      .N (REQ_N)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (w_cand[o]),
      .grant     (w_arb_gnt[o]),
      .update_en (w_free_any[o])
    );
  end

  // Merge per-output winners into per-requester grants and busy-set pulses.
  // Each requester targets one output, so at most one output grants it.
  always_comb begin
    w_gnt_flat = '0;
    w_asg_flat = '0;
    w_set      = '0;
    for (int o = 0; o < in_Port_Cnt; o++) begin
      if (w_free_any[o]) begin
        w_gnt_flat = w_gnt_flat | w_arb_gnt[o];
        for (int k = 0; k < REQ_N; k++) begin
          if (w_arb_gnt[o][k]) begin
            w_asg_flat[k] = w_free_vc[o];
          end
        end
        if (|w_arb_gnt[o]) begin
          w_set[o][w_free_vc[o]] = 1'b1;
        end
      end
    end
  end

  // Grants are combinational but held at zero while reset is asserted.
  assign vc_grant_o    = rst_n ? w_gnt_flat : '0;
  assign vc_assigned_o = rst_n ? w_asg_flat : '0;

  // Occupancy: a release drops a held VC; a new grant only ever claims a free
  // one, so a release aimed at it is meaningless and the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~release_i) | w_set;
    end
  end

  assign vc_busy_o = r_busy;

endmodule

// File: tb/tb_vc_allocator.sv
// Bench for vc_allocator: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_vc_allocator;
  import params_noc::*;

  localparam int P  = in_Port_Cnt;
  localparam int V  = VC_NUM;
  localparam int K  = REQ_CNT;
  localparam int VW = $clog2(VC_NUM);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [P-1:0][V-1:0]             vc_req   = '0;
  logic [P-1:0][V-1:0]             rel      = '0;
  logic [P-1:0][V-1:0][PORT_W-1:0] out_port = '0;
  logic [P-1:0][V-1:0]             vc_grant;
  logic [P-1:0][V-1:0][VW-1:0]     vc_assigned;
  logic [P-1:0][V-1:0]             vc_busy;

  int total = 0;
  int bad   = 0;

  // Model state: owner-less occupancy and round-robin start per output.
  int m_ptr[P];
  bit m_busy[P][V];

  always #5 clk = ~clk;

  vc_allocator #(.vc_Num(V)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vc_req_i      (vc_req),
    .out_port_i    (out_port),
    .release_i     (rel),
    .vc_grant_o    (vc_grant),
    .vc_assigned_o (vc_assigned),
    .vc_busy_o     (vc_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [K-1:0] bitk(input int k);
    logic [K-1:0] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic model_clear();
    for (int o = 0; o < P; o++) begin
      m_ptr[o] = 0;
      for (int v = 0; v < V; v++) m_busy[o][v] = 1'b0;
    end
  endtask

  task automatic set_req(input int ip, input int v, input port_t o);
    vc_req[ip][v]   = 1'b1;
    out_port[ip][v] = o;
  endtask

  // One clock: note what was granted, then drop those requests after the edge.
  task automatic cyc();
    logic [K-1:0] g;
    @(negedge clk);
    g = vc_grant;
    @(posedge clk);
    #1;
    vc_req = vc_req & ~g;
    rel    = '0;
  endtask

  // Asynchronous reset pulse; optionally with random requests held during it.
  task automatic do_reset(input bit noisy);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    if (noisy) begin
      for (int k = 0; k < K; k++) begin
        vc_req[k / V][k % V]   = 1'($urandom_range(1));
        out_port[k / V][k % V] = PORT_W'($urandom_range(4));
      end
    end
    #1;
    check("reset_busy_immediate", vc_busy, '0);
    check("reset_grant_immediate", vc_grant, '0);
    if (noisy) repeat (3) @(negedge clk);
    else @(negedge clk);
    #1;
    vc_req = '0;
    rel    = '0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model, which then advances one cycle:
  // per output, first requester in rotation order from ptr gets the lowest
  // VC that was free at the start of the cycle.
  always @(negedge clk) begin
    logic [K-1:0]    e_gnt;
    logic [K*VW-1:0] e_asg;
    logic [K-1:0]    e_busy;
    int              best;
    int              free;
    int              k;
    if (!rst_n) begin
      check("reset_grant", vc_grant, '0);
      check("reset_assigned", vc_assigned, '0);
      check("reset_busy", vc_busy, '0);
    end else begin
      e_gnt = '0;
      e_asg = '0;
      for (int o = 0; o < P; o++)
        for (int v = 0; v < V; v++) e_busy[o * V + v] = m_busy[o][v];
      check("busy", vc_busy, e_busy);
      for (int o = 0; o < P; o++) begin
        best = -1;
        for (int i = 0; i < K; i++) begin
          k = (m_ptr[o] + i) % K;
          if (best < 0 && vc_req[k / V][k % V] && int'(out_port[k / V][k % V]) == o) best = k;
        end
        free = -1;
        for (int v = V - 1; v >= 0; v--) if (!m_busy[o][v]) free = v;
        for (int v = 0; v < V; v++) if (rel[o][v]) m_busy[o][v] = 1'b0;
        if (best >= 0 && free >= 0) begin
          e_gnt[best]            = 1'b1;
          e_asg[best * VW +: VW] = VW'(free);
          m_ptr[o]               = (best + 1) % K;
          m_busy[o][free]        = 1'b1;
        end
      end
      check("grant", vc_grant, e_gnt);
      check("assigned", vc_assigned, e_asg);
    end
  end

  int ck[3];
  int ek[4];

  initial begin
    model_clear();

    // Reset with random requests present, then idle after release.
    do_reset(1'b1);
    check("post_reset_idle", vc_grant, '0);
    cyc();

    // Single request: NORTH vc2 (k=6) -> EAST.
    set_req(1, 2, EAST);
    #1;
    check("single_grant", vc_grant, bitk(6));
    check("single_assigned", vc_assigned[1][2], 0);
    cyc();
    check("single_busy", vc_busy[EAST], 4'b0001);

    // Contention on EAST: k=0, 9, 19 granted in order with VCs 0, 1, 2.
    do_reset(1'b0);
    set_req(0, 0, EAST);
    set_req(2, 1, EAST);
    set_req(4, 3, EAST);
    ck = '{0, 9, 19};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("contend_grant", vc_grant, bitk(ck[i]));
      check("contend_assigned", vc_assigned[ck[i] / V][ck[i] % V], i);
      cyc();
    end
    check("contend_busy", vc_busy[EAST], 4'b0111);

    // Exhaustion on WEST: four grants take VCs 0-3, the fifth waits for a release.
    do_reset(1'b0);
    set_req(0, 1, WEST);
    set_req(1, 0, WEST);
    set_req(2, 2, WEST);
    set_req(3, 3, WEST);
    set_req(4, 0, WEST);
    ek = '{1, 4, 10, 15};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("exhaust_grant", vc_grant, bitk(ek[i]));
      check("exhaust_assigned", vc_assigned[ek[i] / V][ek[i] % V], i);
      cyc();
    end
    #1;
    check("exhaust_full_busy", vc_busy[WEST], 4'b1111);
    check("exhaust_wait", vc_grant, '0);
    cyc();
    rel[WEST][1] = 1'b1;
    #1;
    check("release_no_bypass", vc_grant, '0);
    cyc();
    #1;
    check("release_regrant", vc_grant, bitk(16));
    check("release_assigned", vc_assigned[4][0], 1);
    cyc();

    // Out-of-encoding port code never wins.
    vc_req[2][0]   = 1'b1;
    out_port[2][0] = 3'd6;
    #1;
    check("bad_port_no_grant", vc_grant, '0);
    cyc();
    vc_req[2][0] = 1'b0;

    // Five distinct outputs granted in the same cycle.
    do_reset(1'b0);
    set_req(0, 0, NORTH);
    set_req(1, 1, SOUTH);
    set_req(2, 2, EAST);
    set_req(3, 3, WEST);
    set_req(4, 0, LOCAL);
    #1;
    check("parallel_grant", vc_grant, bitk(0) | bitk(5) | bitk(10) | bitk(15) | bitk(16));
    check("parallel_count", $countones(vc_grant), 5);
    cyc();

    // Wrap: grant k=18 so ptr[NORTH]=19, then k=19 beats k=0.
    do_reset(1'b0);
    set_req(4, 2, NORTH);
    #1;
    check("wrap_setup", vc_grant, bitk(18));
    cyc();
    set_req(4, 3, NORTH);
    set_req(0, 0, NORTH);
    #1;
    check("wrap_first", vc_grant, bitk(19));
    check("wrap_first_vc", vc_assigned[4][3], 1);
    cyc();
    #1;
    check("wrap_second", vc_grant, bitk(0));
    check("wrap_second_vc", vc_assigned[0][0], 2);
    cyc();
    check("wrap_busy", vc_busy[NORTH], 4'b0111);

    // Mid-operation reset discards the three held VCs.
    do_reset(1'b0);
    set_req(3, 1, NORTH);
    #1;
    check("after_reset_grant", vc_grant, bitk(13));
    check("after_reset_vc", vc_assigned[3][1], 0);
    cyc();
    check("after_reset_busy", vc_busy[NORTH], 4'b0001);

    // Randomized traffic; every cycle is checked by the model process.
    do_reset(1'b0);
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < K; k++) begin
        int ip;
        int v;
        ip = k / V;
        v  = k % V;
        if (!vc_req[ip][v]) begin
          if ($urandom_range(3) == 0) begin
            vc_req[ip][v]   = 1'b1;
            out_port[ip][v] = ($urandom_range(15) == 0) ? PORT_W'($urandom_range(7, 5))
                                                        : PORT_W'($urandom_range(4));
          end
        end else if (out_port[ip][v] > 3'd4 && $urandom_range(7) == 0) begin
          vc_req[ip][v] = 1'b0;
        end
      end
      for (int o = 0; o < P; o++)
        for (int v = 0; v < V; v++)
          rel[o][v] = (m_busy[o][v] && $urandom_range(5) == 0) || ($urandom_range(40) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_allocator.md
# vc_allocator

Assigns downstream virtual channels to packet heads in the router. Each input VC requests one output port, as computed by route computation. The allocator tracks which downstream VCs of every output port are held by an in-flight packet, and grants each output's next free VC to one requester per cycle using round-robin fairness. It sits between route computation and the switch allocator (`in_out_allocator`): only input VCs that hold a downstream VC go on to request the crossbar.

## Interface
Parameters:
- `vc_Num`, default 4: VCs per port, both upstream and downstream.
- `in_Port_Cnt` is not a parameter; it comes from `params_noc` (5 ports).

Ports:
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `vc_req_i`, input, `[in_Port_Cnt-1:0][vc_Num-1:0]`: the input VC holds an unallocated head flit.
- `out_port_i`, input, `port_t [in_Port_Cnt-1:0][vc_Num-1:0]`: requested output port per input VC. Stable while the request is high.
- `release_i`, input, `[in_Port_Cnt-1:0][vc_Num-1:0]`: indexed by [output port][downstream VC]. Pulse when the tail flit of the packet holding that VC leaves.
- `vc_grant_o`, output, `[in_Port_Cnt-1:0][vc_Num-1:0]`: one-cycle grant per input VC.
- `vc_assigned_o`, output, `[in_Port_Cnt-1:0][vc_Num-1:0][$clog2(vc_Num)-1:0]`: downstream VC id. Valid only while the matching grant bit is high, otherwise 0.
- `vc_busy_o`, output, `[in_Port_Cnt-1:0][vc_Num-1:0]`: registered occupancy per [output port][downstream VC].

## Operation
- Requester index: k = ip*vc_Num + vc, with range 0..in_Port_Cnt*vc_Num-1 (0..19).
- Per output port o:
  - The candidate set is every k with `vc_req_i` high and `out_port_i == o`.
  - A round-robin pointer `ptr[o]` selects the first candidate at or after `ptr[o]`, wrapping at 19→0.
  - The selected requester receives the lowest-index downstream VC v with `busy[o][v]==0`.
- At most one grant per output per cycle. Different outputs grant independently in the same cycle.
- An input VC targets exactly one output, so an input VC receives at most one grant per cycle.
- On a grant (o, k, v), at the rising edge:
  - `busy[o][v]` is set.
  - `ptr[o]` becomes (k+1) mod 20.
- If output o has no candidates, or all its VCs are busy:
  - no grant;
  - `ptr[o]` unchanged.
- Release: `release_i[o][v]` clears `busy[o][v]` at the edge.
  - A release of a VC that is not busy is ignored.
  - No bypass: a VC released in cycle t is grantable from cycle t+1.
- A requester must deassert `vc_req_i` in the cycle after it sees its grant. The allocator does not mask repeated requests.
- `out_port_i` values outside the `inout_Port` encoding produce no candidate and no grant.

## Timing
- Grant latency is 0 cycles. `vc_grant_o` and `vc_assigned_o` are combinational from the registered `busy`/`ptr` state and the current requests.
- `vc_busy_o` reflects a grant or release one cycle later.
- Reset (asynchronous, immediate):
  - `busy` = 0 and all `ptr` = 0.
  - `vc_grant_o` and `vc_assigned_o` are forced to 0 while `rst_n` is low.
  - `vc_busy_o` = 0.
- Reset mid-operation discards all allocations. Upstream logic is reset by the same `rst_n`.
- Starvation bound: any continuously requesting input VC is granted within 20 grants of its output port.

## Structure
- `params_noc` holds `in_Port_Cnt`, `port_t`/`inout_Port`, and a new localparam `REQ_CNT = in_Port_Cnt*vc_Num`.
- Sub-module `round_robin_arbiter #(N)`:
  - ports: clk, rst_n, req[N], grant[N], update_en;
  - owns its pointer;
  - instantiated once per output port with N = REQ_CNT;
  - `update_en` is high only when a free VC exists.
- Top level contains:
  - the candidate decode by `out_port_i`;
  - the lowest-free-VC priority encoder per output;
  - the busy registers.

## Test plan
- Reset: assert `rst_n` low with random requests → all grants 0, `vc_busy_o`=0. Release reset with no requests → no grants.
- Single request: NORTH vc2 → EAST:
  - same cycle: grant[NORTH][2]=1, assigned=0;
  - next cycle: busy[EAST]=4'b0001.
- Contention: LOCAL vc0, SOUTH vc1, WEST vc3 all → EAST, held until granted. Expect:
  - one grant per cycle in ascending k order;
  - assigned VCs 0, 1, 2;
  - busy[EAST]=4'b0111.
- Exhaustion and release: five requesters → WEST.
  - Four grants take VCs 0–3; the fifth waits.
  - Pulse release[WEST][1] in cycle t: no grant in t; grant with VC 1 in t+1.
- Parallel and wrap:
  - Five input VCs request five distinct outputs in the same cycle → five grants that cycle.
  - With `ptr`=19 and requesters k=19 and k=0: k=19 is granted first, then k=0.
- Reset mid-operation: with 3 VCs busy, pulse `rst_n` low for half a cycle → `vc_busy_o`=0 immediately. A subsequent request receives VC 0.
